// File: rtl/imm_encoder_pkg.sv
// Shared decode definitions: immediate formats, per-format legal ranges,
// and error codes reported by the immediate encoder.
package imm_encoder_pkg;

  // Same encoding the decode-stage extender uses for ImmSrc.
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // Inclusive signed limits of the immediate each format can carry.
  localparam logic signed [31:0] IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IS_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN  = -32'sd4096;
  localparam logic signed [31:0] B_MAX  = 32'sd4094;
  localparam logic signed [31:0] J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] J_MAX  = 32'sd1048574;

  // Reasons a bundle is rejected.
  localparam logic [1:0] ERR_RANGE    = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;

  // True when v lies inside [lo, hi].
  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational field scatter into the RISC-V I/S/B/J layouts, plus the
// alignment and range check of the immediate for the selected format.
module imm_encoder_pack
  import imm_encoder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  imm_src_e         imm_src,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] word,
  output logic             legal,
  output logic [1:0]       err_code
);

  logic [31:0]        word_s;
  logic signed [31:0] imm_sv_s;
  logic signed [31:0] lo_s;
  logic signed [31:0] hi_s;
  logic               odd_s;

  assign imm_sv_s = imm[31:0];
  assign word     = word_s;

  // Scatter the immediate for the selected format and classify it; misalignment wins over range.
  always_comb begin
    word_s = 32'h0000_0000;
    lo_s   = IS_MIN;
    hi_s   = IS_MAX;
    odd_s  = 1'b0;
    case (imm_src)
      IMM_I: word_s = {imm[11:0], rs1, funct3, rd, opcode};
      IMM_S: word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMM_B: begin
        word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        lo_s   = B_MIN;
        hi_s   = B_MAX;
        odd_s  = imm[0];
      end
      IMM_J: begin
        word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        lo_s   = J_MIN;
        hi_s   = J_MAX;
        odd_s  = imm[0];
      end
      default: word_s = 32'h0000_0000;
    endcase

    if (odd_s) begin
      legal    = 1'b0;
      err_code = ERR_MISALIGN;
    end else if (!in_range(imm_sv_s, lo_s, hi_s)) begin
      legal    = 1'b0;
      err_code = ERR_RANGE;
    end else begin
      legal    = 1'b1;
      err_code = ERR_RANGE;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: accepts instruction fields plus a signed immediate,
// packs them into a RISC-V instruction word and streams the words into
// instruction memory at consecutive addresses. Two-stage pipeline:
// stage 1 captures the packed word and its check result, stage 2 drives
// the memory write port or raises a one-cycle error pulse.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            ImmSrc,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [WIDTH-1:0]      imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ready,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [WIDTH-1:0]      pack_word_s;
  logic                  pack_legal_s;
  logic [1:0]            pack_err_s;

  logic                  s1_valid_r;
  logic                  s1_legal_r;
  logic [1:0]            s1_err_r;
  logic [WIDTH-1:0]      s1_word_r;

  logic                  mem_we_r;
  logic [WIDTH-1:0]      mem_wdata_r;
  logic                  err_valid_r;
  logic [1:0]            err_code_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  wrapped_r;

  logic                  s2_advance_s;
  logic                  in_ready_s;
  logic                  write_done_s;

  imm_encoder_pack #(.WIDTH(WIDTH)) u_pack (
    .imm_src  (imm_src_e'(ImmSrc)),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .imm      (imm),
    .word     (pack_word_s),
    .legal    (pack_legal_s),
    .err_code (pack_err_s)
  );

  // Only a pending write can stall stage 2; an error bundle always retires.
  assign s2_advance_s = !mem_we_r || mem_ready;
  assign in_ready_s   = !rst && (!s1_valid_r || s2_advance_s);
  assign write_done_s = mem_we_r && mem_ready;

  assign in_ready  = in_ready_s;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign err_valid = err_valid_r;
  assign err_code  = err_code_r;
  assign mem_addr  = mem_addr_r;
  assign wrapped   = wrapped_r;

  // Two-stage pipeline: capture the packed bundle, then present it as a write or an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_legal_r  <= 1'b0;
      s1_err_r    <= ERR_RANGE;
      s1_word_r   <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
      err_valid_r <= 1'b0;
      err_code_r  <= ERR_RANGE;
    end else begin
      if (in_ready_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_legal_r <= pack_legal_s;
          s1_err_r   <= pack_err_s;
          s1_word_r  <= pack_word_s;
        end
      end
      if (s2_advance_s) begin
        mem_we_r    <= s1_valid_r && s1_legal_r;
        err_valid_r <= s1_valid_r && !s1_legal_r;
        if (s1_valid_r && s1_legal_r) begin
          mem_wdata_r <= s1_word_r;
        end
        if (s1_valid_r && !s1_legal_r) begin
          err_code_r <= s1_err_r;
        end
      end
    end
  end

  // Write address: advance on each accepted write, wrap with a sticky flag, reload on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r <= BASE;
      wrapped_r  <= 1'b0;
    end else if (start) begin
      mem_addr_r <= BASE;
      wrapped_r  <= 1'b0;
    end else if (write_done_s) begin
      mem_addr_r <= mem_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (&mem_addr_r) begin
        wrapped_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a 2-bit address port so wrap-around
// is reachable. A monitor records completed writes and error pulses; each
// test task drives its scenario and compares against hand-computed values.
module tb_imm_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    ImmSrc = 2'b00;
  logic [6:0]    opcode = 7'h00;
  logic [4:0]    rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]    funct3 = 3'd0;
  logic [31:0]   imm = 32'h0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b1;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          wrapped;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          wrp;
    int            cyc;
  } wrec_t;

  wrec_t      wq[$];
  logic [1:0] eq[$];

  imm_encoder #(.WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .err_valid(err_valid), .err_code(err_code), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write that will complete at the next edge, and every error pulse.
  always @(negedge clk) begin
    wrec_t r;
    #2;
    if (!rst && mem_we && mem_ready) begin
      r.addr = mem_addr; r.data = mem_wdata; r.wrp = wrapped; r.cyc = cyc;
      wq.push_back(r);
    end
    if (!rst && err_valid) eq.push_back(err_code);
  end

  // Decode-stage immediate extender, used as the round-trip reference.
  function automatic logic [31:0] decode_ext(input logic [31:0] w, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one bundle at a falling edge and return at the falling edge after it is accepted.
  task automatic send(input logic [1:0] src, input logic [6:0] opc, input logic [4:0] rd_i,
                      input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                      input logic [2:0] f3, input logic [31:0] im);
    int n;
    ImmSrc = src; opcode = opc; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; funct3 = f3; imm = im;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
    tick(2);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 2'd0) begin miscompares++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
    vectors++; if (err_code !== 2'b00) begin miscompares++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
    @(negedge clk);
  endtask

  task automatic test_i_type();
    pulse_start();
    wq.delete();
    send(2'b00, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF);
    #1;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL addi_early_we: got %b want 0", mem_we); end
    @(negedge clk); #1;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL addi_we: got %b want 1", mem_we); end
    vectors++; if (mem_addr !== 2'd0) begin miscompares++; $display("FAIL addi_addr: got %0d want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'hFFF3_0293) begin miscompares++; $display("FAIL addi_wdata: got %h want fff30293", mem_wdata); end
    tick(3);
    vectors++; if (wq.size() !== 1) begin miscompares++; $display("FAIL addi_write_count: got %0d want 1", wq.size()); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    wq.delete();
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    send(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    tick(4);
    vectors++; if (wq.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", wq.size()); end
    if (wq.size() == 2) begin
      vectors++; if (wq[0].data !== 32'h0020_8463 || wq[0].addr !== 2'd0) begin miscompares++; $display("FAIL b2b_beq: got %h@%0d want 00208463@0", wq[0].data, wq[0].addr); end
      vectors++; if (wq[1].data !== 32'h0010_00EF || wq[1].addr !== 2'd1) begin miscompares++; $display("FAIL b2b_jal: got %h@%0d want 001000ef@1", wq[1].data, wq[1].addr); end
      vectors++; if (wq[1].cyc !== wq[0].cyc + 1) begin miscompares++; $display("FAIL b2b_consecutive: got gap %0d want 1", wq[1].cyc - wq[0].cyc); end
    end
  endtask

  task automatic test_errors();
    logic [1:0] exp_e[6];
    exp_e = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    pulse_start();
    wq.delete(); eq.delete();
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    #1;
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL err_early: got %b want 0", err_valid); end
    @(negedge clk); #1;
    vectors++; if (err_valid !== 1'b1 || err_code !== 2'b01) begin miscompares++; $display("FAIL err_misalign_pulse: got %b/%b want 1/01", err_valid, err_code); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL err_no_write: got %b want 0", mem_we); end
    @(negedge clk); #1;
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle: got %b want 0", err_valid); end
    send(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd2048);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5001);
    send(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1048576);
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd2049);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4098);
    tick(4);
    vectors++; if (eq.size() !== 6) begin miscompares++; $display("FAIL err_count: got %0d want 6", eq.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < eq.size()) begin
        vectors++; if (eq[k] !== exp_e[k]) begin miscompares++; $display("FAIL err_code_%0d: got %b want %b", k, eq[k], exp_e[k]); end
      end
    end
    vectors++; if (wq.size() !== 0) begin miscompares++; $display("FAIL err_wrote: got %0d writes want 0", wq.size()); end
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick(4);
    vectors++; if (wq.size() !== 1) begin miscompares++; $display("FAIL err_followup_count: got %0d want 1", wq.size()); end
    if (wq.size() == 1) begin
      vectors++; if (wq[0].addr !== 2'd0 || wq[0].data !== 32'h0050_0093) begin miscompares++; $display("FAIL err_followup: got %h@%0d want 00500093@0", wq[0].data, wq[0].addr); end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] exp_w[6];
    exp_w = '{32'h7FF0_0093, 32'h8074_2023, 32'h7E00_0FE3, 32'h8000_0063, 32'h8000_006F, 32'h7FFF_F06F};
    pulse_start();
    wq.delete();
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2047);
    send(2'b01, 7'h23, 5'd0, 5'd8, 5'd7, 3'd2, -32'sd2048);
    send(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094);
    send(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4096);
    send(2'b11, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd1048576);
    send(2'b11, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1048574);
    tick(4);
    vectors++; if (wq.size() !== 6) begin miscompares++; $display("FAIL bound_count: got %0d want 6", wq.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < wq.size()) begin
        vectors++; if (wq[k].data !== exp_w[k]) begin miscompares++; $display("FAIL bound_word_%0d: got %h want %h", k, wq[k].data, exp_w[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    wq.delete();
    mem_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(2'b00, 7'h13, i[4:0], 5'd0, 5'd0, 3'd0, 32'(i));
      end
      begin
        tick(2);
        for (int k = 0; k < 3; k++) begin
          #2;
          vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready); end
          vectors++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h0010_0093) begin miscompares++; $display("FAIL bp_hold_%0d: got we=%b %h@%0d want we=1 00100093@0", k, mem_we, mem_wdata, mem_addr); end
          @(negedge clk);
        end
        mem_ready = 1'b1;
      end
    join
    tick(5);
    vectors++; if (wq.size() !== 4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", wq.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < wq.size()) begin
        vectors++;
        if (wq[k].data !== ((32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13) || wq[k].addr !== 2'(k)) begin
          miscompares++; $display("FAIL bp_order_%0d: got %h@%0d want bundle %0d at %0d", k, wq[k].data, wq[k].addr, k + 1, k);
        end
      end
    end
  endtask

  task automatic test_wrap_and_start();
    logic [AW-1:0] exp_a[5];
    logic          exp_f[5];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_start();
    wq.delete();
    for (int i = 0; i < 5; i++) send(2'b00, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'(i));
    tick(4);
    vectors++; if (wq.size() !== 5) begin miscompares++; $display("FAIL wrap_count: got %0d want 5", wq.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < wq.size()) begin
        vectors++; if (wq[k].addr !== exp_a[k] || wq[k].wrp !== exp_f[k]) begin miscompares++; $display("FAIL wrap_seq_%0d: got addr %0d wrapped %b want %0d %b", k, wq[k].addr, wq[k].wrp, exp_a[k], exp_f[k]); end
      end
    end
    vectors++; if (wrapped !== 1'b1) begin miscompares++; $display("FAIL wrap_sticky: got %b want 1", wrapped); end
    wq.delete();
    send(2'b00, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd9);
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++; if (mem_addr !== 2'd0 || wrapped !== 1'b0) begin miscompares++; $display("FAIL start_reload: got addr %0d wrapped %b want 0 0", mem_addr, wrapped); end
    send(2'b00, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd10);
    tick(4);
    vectors++; if (wq.size() !== 2) begin miscompares++; $display("FAIL start_count: got %0d want 2", wq.size()); end
    if (wq.size() == 2) begin
      vectors++; if (wq[0].addr !== 2'd1) begin miscompares++; $display("FAIL start_coincident_addr: got %0d want 1", wq[0].addr); end
      vectors++; if (wq[1].addr !== 2'd0) begin miscompares++; $display("FAIL start_next_addr: got %0d want 0", wq[1].addr); end
    end
  endtask

  task automatic test_round_trip();
    logic [1:0]  srcq[$];
    logic [31:0] immq[$];
    logic [6:0]  opcq[$];
    logic [1:0]  s;
    logic [6:0]  o;
    int          v;
    pulse_start();
    wq.delete();
    for (int i = 0; i < 10000; i++) begin
      s = 2'($urandom_range(0, 3));
      o = 7'($urandom_range(0, 127));
      case (s)
        2'b00, 2'b01: v = int'($urandom_range(0, 4095)) - 2048;
        2'b10:        v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        default:      v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      endcase
      srcq.push_back(s); immq.push_back(32'(v)); opcq.push_back(o);
      send(s, o, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           3'($urandom_range(0, 7)), 32'(v));
    end
    tick(4);
    vectors++; if (wq.size() !== 10000) begin miscompares++; $display("FAIL rt_count: got %0d want 10000", wq.size()); end
    for (int k = 0; k < 10000; k++) begin
      if (k < wq.size()) begin
        vectors++; if (decode_ext(wq[k].data, srcq[k]) !== immq[k]) begin miscompares++; $display("FAIL rt_imm_%0d: got %h want %h", k, decode_ext(wq[k].data, srcq[k]), immq[k]); end
        vectors++; if (wq[k].data[6:0] !== opcq[k]) begin miscompares++; $display("FAIL rt_opcode_%0d: got %h want %h", k, wq[k].data[6:0], opcq[k]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    wq.delete();
    send(2'b00, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd1);
    tick(4);
    wq.delete();
    send(2'b00, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd2);
    send(2'b00, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 2'd0) begin miscompares++; $display("FAIL rst_mid_state: got we=%b addr=%0d want 0 0", mem_we, mem_addr); end
    tick(4);
    vectors++; if (wq.size() !== 0) begin miscompares++; $display("FAIL rst_mid_writes: got %0d want 0", wq.size()); end
    vectors++; if (mem_addr !== 2'd0) begin miscompares++; $display("FAIL rst_mid_addr: got %0d want 0", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_back_to_back();
    test_errors();
    test_boundaries();
    test_backpressure();
    test_wrap_and_start();
    test_round_trip();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
